// File: rtl/mem_port_ctrl.sv
// Shares block memory: round-robin read arbitration into a 1-deep response buffer, block writes serialized to FETCH beats.
// Read grant->rsp_valid 1 cycle; response held while !i_rsp_ready; reads stall during a write burst; o_wr_ready low in BURST.
module mem_port_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 12,
    parameter int SIZE    = 32,
    parameter int FETCH   = 4,
    parameter int STRIDE  = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_REQ-1:0]                i_rd_req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    i_rd_addr,
    output logic [NUM_REQ-1:0]                o_rd_gnt,
    output logic                              o_rsp_valid,
    output logic [ID_W-1:0]                   o_rsp_id,
    output logic [FETCH-1:0][SIZE-1:0]        o_rsp_data,
    input  logic                              i_rsp_ready,
    input  logic                              i_wr_valid,
    input  logic [ADDR_W-1:0]                 i_wr_addr,
    input  logic [FETCH-1:0][SIZE-1:0]        i_wr_data,
    output logic                              o_wr_ready,
    output logic [ADDR_W-1:0]                 o_mem_addr_r,
    input  logic [FETCH-1:0][SIZE-1:0]        i_mem_data,
    output logic [ADDR_W-1:0]                 o_mem_addr_w,
    output logic [SIZE-1:0]                   o_mem_data_w,
    output logic                              o_mem_wr_en
);

    localparam int K_W = (FETCH > 1) ? $clog2(FETCH) : 1;

    typedef enum logic {IDLE, BURST} wr_state_t;

    wr_state_t                  state_q;
    logic [K_W-1:0]             beat_q;
    logic [FETCH-1:0][SIZE-1:0] blk_q;
    logic [ADDR_W-1:0]          addr_w_q;
    logic                       wr_en_q;

    logic                       rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
    logic [FETCH-1:0][SIZE-1:0] rsp_dat_q, rsp_dat_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [ADDR_W-1:0]          addr_r_q, addr_r_d;

    logic                       hit;
    logic                       gnt_en;
    logic [ID_W-1:0]            win;
    logic [ID_W-1:0]            cand;

    // Write burst: element FETCH-1 lands at base, so blk_q shifts toward the top each beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            blk_q    <= '0;
            addr_w_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_wr_valid) begin
                        state_q  <= BURST;
                        beat_q   <= '0;
                        blk_q    <= i_wr_data;
                        addr_w_q <= i_wr_addr;
                        wr_en_q  <= 1'b1;
                    end
                end
                BURST: begin
                    blk_q    <= blk_q << SIZE;
                    addr_w_q <= addr_w_q + ADDR_W'(STRIDE);
                    beat_q   <= beat_q + 1'b1;
                    if (beat_q == K_W'(FETCH - 1)) begin
                        state_q <= IDLE;
                        wr_en_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_wr_ready   = (state_q == IDLE);
    assign o_mem_wr_en  = wr_en_q;
    assign o_mem_addr_w = addr_w_q;
    assign o_mem_data_w = blk_q[FETCH-1];

    // Search starts one past the last winner, wrapping, so every requester is served in turn.
    always_comb begin
        hit  = 1'b0;
        win  = ptr_q;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!hit && i_rd_req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    assign gnt_en       = (state_q == IDLE) && (!rsp_vld_q || i_rsp_ready) && hit;
    assign o_rd_gnt     = gnt_en ? (NUM_REQ'(1) << win) : '0;
    assign o_mem_addr_r = gnt_en ? i_rd_addr[win] : addr_r_q;

    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_dat_d = rsp_dat_q;
        ptr_d     = ptr_q;
        addr_r_d  = addr_r_q;
        if (gnt_en) begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = win;
            rsp_dat_d = i_mem_data;
            ptr_d     = win;
            addr_r_d  = i_rd_addr[win];
        end else if (i_rsp_ready) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_dat_q <= '0;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            addr_r_q  <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_dat_q <= rsp_dat_d;
            ptr_q     <= ptr_d;
            addr_r_q  <= addr_r_d;
        end
    end

    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_dat_q;

endmodule
